// File: rtl/lsu_axi_master.sv
// Load/store unit: turns one EXU memory request at a time into a single-beat AXI4
// read or write, with lane steering, load extension and explicit error reporting.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  localparam int LANES = DATA_W / 8,
  localparam int OFF_W = $clog2(LANES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              io_master_awvalid,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [ID_W-1:0]   io_master_awid,
  output logic [7:0]        io_master_awlen,
  output logic [2:0]        io_master_awsize,
  output logic [1:0]        io_master_awburst,
  input  logic              io_master_awready,
  output logic              io_master_wvalid,
  output logic [DATA_W-1:0] io_master_wdata,
  output logic [LANES-1:0]  io_master_wstrb,
  output logic              io_master_wlast,
  input  logic              io_master_wready,
  input  logic              io_master_bvalid,
  input  logic [1:0]        io_master_bresp,
  input  logic [ID_W-1:0]   io_master_bid,
  output logic              io_master_bready,
  output logic              io_master_arvalid,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [ID_W-1:0]   io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  input  logic              io_master_arready,
  input  logic              io_master_rvalid,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic [ID_W-1:0]   io_master_rid,
  input  logic              io_master_rlast,
  output logic              io_master_rready
);

  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, ERR} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [LANES-1:0]    strb_reg, strb_next;
  logic [1:0]          size_reg, size_next;
  logic                signed_reg, signed_next;
  logic [ID_W-1:0]     id_reg, id_next;
  logic [ID_W-1:0]     id_cnt_reg, id_cnt_next;
  logic                aw_done_reg, aw_done_next;
  logic                w_done_reg, w_done_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic                rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;

  logic [OFF_W-1:0]    req_off, rd_off;
  logic                misaligned;
  logic [LANES-1:0]    req_strb;
  logic [DATA_W-1:0]   req_wdata_steer, rd_shift, load_ext;
  int                  load_nbits;
  logic                load_sign;
  logic                aw_hs, w_hs, b_err, r_err;

  // Request-side alignment check and store lane steering, computed before latching.
  always_comb begin
    req_off         = req_addr[OFF_W-1:0];
    misaligned      = (int'(req_size) > OFF_W) ||
                      ((req_off & OFF_W'((1 << req_size) - 1)) != '0);
    req_strb        = LANES'(((1 << (1 << req_size)) - 1) << req_off);
    req_wdata_steer = req_wdata << {req_off, 3'b000};
  end

  // Load path: shift the addressed bytes down, then mask and extend above the access width.
  always_comb begin
    rd_off     = addr_reg[OFF_W-1:0];
    rd_shift   = io_master_rdata >> {rd_off, 3'b000};
    load_nbits = 8 << size_reg;
    load_sign  = signed_reg & rd_shift[BIT_W'(load_nbits - 1)];
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
    assign load_ext[gi] = (gi < load_nbits) ? rd_shift[gi] : load_sign;
  end

  assign aw_hs = io_master_awvalid && io_master_awready;
  assign w_hs  = io_master_wvalid && io_master_wready;
  assign b_err = (io_master_bid != id_reg) || (io_master_bresp != 2'b00);
  assign r_err = (io_master_rid != id_reg) || (io_master_rresp != 2'b00) || !io_master_rlast;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    strb_next      = strb_reg;
    size_next      = size_reg;
    signed_next    = signed_reg;
    id_next        = id_reg;
    id_cnt_next    = id_cnt_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_next    = req_addr;
          wdata_next   = req_wdata_steer;
          strb_next    = req_strb;
          size_next    = req_size;
          signed_next  = req_signed;
          id_next      = id_cnt_reg;
          id_cnt_next  = id_cnt_reg + ID_W'(1);
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          if (misaligned)   state_next = ERR;
          else if (req_wen) state_next = WR;
          else              state_next = RADDR;
        end
      end
      WR: begin
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_hs;
        if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) state_next = WRESP;
      end
      WRESP: begin
        if (io_master_bvalid) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = b_err;
          state_next     = IDLE;
        end
      end
      RADDR: begin
        if (io_master_arready) state_next = RDATA;
      end
      RDATA: begin
        if (io_master_rvalid) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = r_err;
          rsp_rdata_next = r_err ? '0 : load_ext;
          state_next     = IDLE;
        end
      end
      ERR: begin
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      strb_reg      <= '0;
      size_reg      <= '0;
      signed_reg    <= 1'b0;
      id_reg        <= '0;
      id_cnt_reg    <= '0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      strb_reg      <= strb_next;
      size_reg      <= size_next;
      signed_reg    <= signed_next;
      id_reg        <= id_next;
      id_cnt_reg    <= id_cnt_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  // The response cycle blocks acceptance so the EXU sees the pulse before the next request.
  assign req_ready = (state_reg == IDLE) && !rsp_valid_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

  assign io_master_awvalid = (state_reg == WR) && !aw_done_reg;
  assign io_master_awaddr  = addr_reg;
  assign io_master_awid    = id_reg;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = {1'b0, size_reg};
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid  = (state_reg == WR) && !w_done_reg;
  assign io_master_wdata   = wdata_reg;
  assign io_master_wstrb   = strb_reg;
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = (state_reg == WRESP);
  assign io_master_arvalid = (state_reg == RADDR);
  assign io_master_araddr  = addr_reg;
  assign io_master_arid    = id_reg;
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = {1'b0, size_reg};
  assign io_master_arburst = 2'b01;
  assign io_master_rready  = (state_reg == RDATA);

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: directed and random transactions against a cycle-stepped
// AXI slave, with expected results derived from byte-level rules of the access.
module tb_lsu_axi_master;

  logic        clock, reset;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, bid, rid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  int n_vec = 0;
  int n_err = 0;
  int id_model = 0;

  lsu_axi_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_master_awvalid(awvalid), .io_master_awaddr(awaddr), .io_master_awid(awid),
    .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_awready(awready),
    .io_master_wvalid(wvalid), .io_master_wdata(wdata), .io_master_wstrb(wstrb),
    .io_master_wlast(wlast), .io_master_wready(wready),
    .io_master_bvalid(bvalid), .io_master_bresp(bresp), .io_master_bid(bid),
    .io_master_bready(bready),
    .io_master_arvalid(arvalid), .io_master_araddr(araddr), .io_master_arid(arid),
    .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_arready(arready),
    .io_master_rvalid(rvalid), .io_master_rdata(rdata), .io_master_rresp(rresp),
    .io_master_rid(rid), .io_master_rlast(rlast), .io_master_rready(rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bid = 0; bresp = 0; rid = 0; rresp = 0; rlast = 0; rdata = 0;
  endtask

  // One request end to end; the slave stalls each channel by the given delays.
  task automatic do_txn(input logic [31:0] addr, input bit wen, input logic [31:0] wd,
                        input logic [1:0] size, input bit sgn,
                        input int aw_d, input int w_d, input int ar_d, input int resp_d,
                        input logic [1:0] resp, input bit bad_id, input bit no_last,
                        input logic [31:0] rsrc, input bit abort);
    int nbytes, off, cyc, wait_cyc, aw_cnt, w_cnt, ar_cnt, both_cyc, ar_cyc, rsp_cyc;
    bit misal, exp_err, aw_got, w_got, ar_got, resp_done, rsp_seen, aw_pend, w_pend, ar_pend;
    logic [3:0]  exp_id, exp_strb;
    logic [31:0] exp_wdata, exp_rdata;
    logic [63:0] val;

    nbytes = 1 << size;
    off    = int'(addr[1:0]);
    misal  = (size == 2'd3) || ((addr % nbytes) != 0);
    exp_err = misal || (resp != 2'b00) || bad_id || (!wen && no_last);
    exp_wdata = 32'(64'(wd) << (8 * off));
    exp_strb  = 4'(((1 << nbytes) - 1) << off);
    val = 64'd0;
    if (!misal) begin
      for (int k = 0; k < nbytes; k++) val |= 64'(rsrc[8*(off+k) +: 8]) << (8 * k);
      if (sgn && val[8*nbytes-1]) val |= ~((64'd1 << (8 * nbytes)) - 64'd1);
    end
    exp_rdata = (exp_err || wen) ? 32'd0 : val[31:0];

    @(negedge clock);
    req_valid = 1; req_addr = addr; req_wen = wen; req_wdata = wd;
    req_size = size; req_signed = sgn;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(negedge clock);
      wait_cyc++;
    end
    chk("req_ready_timeout", req_ready, 1);
    exp_id = 4'(id_model);
    id_model = (id_model + 1) % 16;

    cyc = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    both_cyc = 1000; ar_cyc = 1000; rsp_cyc = 1000;
    aw_got = 0; w_got = 0; ar_got = 0; resp_done = 0; rsp_seen = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0;
    while (cyc < 60 && !(rsp_seen && cyc > rsp_cyc)) begin
      @(negedge clock);
      cyc++;
      req_valid = 0;
      if (abort && rready) begin
        rvalid = 0;
        reset = 1;
        @(negedge clock);
        chk("rst_mid_rready", rready, 0);
        chk("rst_mid_arvalid", arvalid, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        reset = 0;
        id_model = 0;
        slave_idle();
        return;
      end
      if (!rsp_seen && rsp_valid) begin
        rsp_seen = 1;
        rsp_cyc = cyc;
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("req_ready_on_rsp", req_ready, 0);
      end else if (rsp_seen) begin
        chk("rsp_single_pulse", rsp_valid, 0);
        chk("req_ready_after_rsp", req_ready, 1);
      end
      if (aw_pend) chk("awvalid_stable", awvalid, 1);
      if (w_pend)  chk("wvalid_stable", wvalid, 1);
      if (ar_pend) chk("arvalid_stable", arvalid, 1);

      awready = (cyc > aw_d);
      wready  = (cyc > w_d);
      arready = (cyc > ar_d);
      bvalid  = wen && aw_got && w_got && !resp_done && (cyc > both_cyc + resp_d);
      bid     = bad_id ? (exp_id ^ 4'h1) : exp_id;
      bresp   = resp;
      rvalid  = !wen && ar_got && !resp_done && (cyc > ar_cyc + resp_d);
      rid     = bad_id ? (exp_id ^ 4'h1) : exp_id;
      rresp   = resp;
      rlast   = !no_last;
      rdata   = rsrc;

      if (aw_got) chk("awvalid_after_hs", awvalid, 0);
      else if (awvalid) begin
        aw_cnt++;
        if (awready) begin
          aw_got = 1;
          chk("awaddr", awaddr, addr);
          chk("awsize", awsize, {1'b0, size});
          chk("awid", awid, exp_id);
          chk("aw_len_burst", {awlen, awburst}, {8'd0, 2'b01});
        end
      end
      if (w_got) chk("wvalid_after_hs", wvalid, 0);
      else if (wvalid) begin
        w_cnt++;
        if (wready) begin
          w_got = 1;
          chk("wdata", wdata, exp_wdata);
          chk("wstrb", wstrb, exp_strb);
          chk("wlast", wlast, 1);
        end
      end
      if (ar_got) chk("arvalid_after_hs", arvalid, 0);
      else if (arvalid) begin
        ar_cnt++;
        if (arready) begin
          ar_got = 1;
          ar_cyc = cyc;
          chk("araddr", araddr, addr);
          chk("arsize", arsize, {1'b0, size});
          chk("arid", arid, exp_id);
          chk("ar_len_burst", {arlen, arburst}, {8'd0, 2'b01});
        end
      end
      aw_pend = awvalid && !awready;
      w_pend  = wvalid && !wready;
      ar_pend = arvalid && !arready;
      if (aw_got && w_got && both_cyc == 1000) both_cyc = cyc;
      if ((bvalid && bready) || (rvalid && rready)) resp_done = 1;
    end
    slave_idle();
    chk("rsp_seen", rsp_seen, 1);
    if (misal) chk("no_axi_on_misalign", aw_cnt + w_cnt + ar_cnt, 0);
    else if (wen) begin
      chk("awvalid_cycles", aw_cnt, aw_d + 1);
      chk("wvalid_cycles", w_cnt, w_d + 1);
      chk("ar_on_store", ar_cnt, 0);
    end else begin
      chk("arvalid_cycles", ar_cnt, ar_d + 1);
      chk("aw_w_on_load", aw_cnt + w_cnt, 0);
    end
    if (!misal && aw_d == 0 && w_d == 0 && ar_d == 0 && resp_d == 0)
      chk("latency", rsp_cyc, 3);
    $display("txn %s addr=%h size=%0d id=%0d rsp_err=%0b rdata=%h",
             wen ? "ST" : "LD", addr, size, exp_id, exp_err, exp_rdata);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    reset = 1; req_valid = 0; req_addr = 0; req_wen = 0; req_wdata = 0;
    req_size = 0; req_signed = 0;
    slave_idle();
    repeat (3) @(negedge clock);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    reset = 0;

    // LB signed, SH with lane steering, AW/W skew, misaligned LW, error responses
    do_txn(32'h8000_0003, 0, 32'h0, 2'd0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 32'h80FF_FFFF, 0);
    do_txn(32'h8000_0002, 1, 32'h0000_1234, 2'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 0);
    do_txn(32'h0000_0100, 1, 32'hCAFE_F00D, 2'd2, 0, 3, 0, 0, 0, 2'b00, 0, 0, 32'h0, 0);
    do_txn(32'h0000_0102, 0, 32'h0, 2'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h1234_5678, 0);
    do_txn(32'h0000_0104, 0, 32'h0, 2'd2, 0, 0, 0, 0, 0, 2'b10, 0, 0, 32'h1234_5678, 0);
    do_txn(32'h0000_0108, 0, 32'h0, 2'd2, 0, 0, 0, 0, 0, 2'b00, 1, 0, 32'h1234_5678, 0);
    do_txn(32'h0000_010C, 0, 32'h0, 2'd1, 0, 0, 0, 0, 0, 2'b00, 0, 1, 32'h1234_5678, 0);
    do_txn(32'h0000_0110, 1, 32'h0000_00AB, 2'd0, 0, 0, 2, 0, 1, 2'b10, 0, 0, 32'h0, 0);
    do_txn(32'h0000_0114, 0, 32'h0, 2'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 0);

    // ID counter wrap across back-to-back loads
    for (int i = 0; i < 17; i++)
      do_txn(32'h0000_2000 + 32'(4 * i), 0, 32'h0, 2'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, $urandom, 0);

    // Reset while waiting in RDATA, then a normal load
    do_txn(32'h0000_3000, 0, 32'h0, 2'd2, 0, 0, 0, 0, 20, 2'b00, 0, 0, 32'h0, 1);
    do_txn(32'h0000_3002, 0, 32'h0, 2'd1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 32'h9ABC_DEF0, 0);

    for (int t = 0; t < 40; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      d  = $urandom;
      do_txn(a, 1'($urandom_range(0, 1)), d, sz, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
